// File: rtl/id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_pkg
//  Description : Shared constants and types for the instruction-decode stage:
//                opcode values, ALU-operation encodings, the main-control
//                bundle and default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package id_stage_pkg;

    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

    // Supported opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU-operation class handed to alu_control in the execute stage
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // Main-control bundle produced by the opcode decoder
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    alu_src;
        logic    illegal;
        alu_op_t alu_op;
    } ctrl_t;

endpackage : id_stage_pkg
`default_nettype wire

// File: rtl/id_stage_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_regfile
//  Description : NREGS x XLEN register file, two combinational read ports and
//                one synchronous write port. Entry 0 is hardwired to zero.
//                A read that hits the address being written in the same cycle
//                returns the write data (write-first), so the decode stage
//                captures the freshest value.
//  Ports       : i_clk, i_rst_n        clock, async active-low reset
//                i_we, i_waddr, i_wdata write port
//                i_raddr1/2, o_rdata1/2 read ports
//  Revision    : 1.0  initial release
// ============================================================================
module id_stage_regfile
    import id_stage_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_active;

    // A write to entry 0 is dropped, so entry 0 stays at its reset value
    assign w_wr_active = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_active) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = '0;
        if (i_raddr1 != '0) begin
            o_rdata1 = (w_wr_active && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
        end
    end

    always_comb begin
        o_rdata2 = '0;
        if (i_raddr2 != '0) begin
            o_rdata2 = (w_wr_active && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
        end
    end

endmodule : id_stage_regfile
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction-decode stage. Decodes main control and the
//                sign-extended immediate, reads two operands from the
//                register file (with write-back bypass) and registers the
//                result into the ID/EX pipeline register. Valid/ready
//                handshake on both sides; i_flush kills the held instruction.
//  Ports       : i_clk, i_rst_n             clock, async active-low reset
//                i_valid/o_ready, i_instr   upstream handshake + instruction
//                i_flush                    kill (branch taken)
//                i_wb_en/i_wb_rd/i_wb_data  register-file write-back
//                o_valid/i_ready            downstream handshake
//                o_rs1_data .. o_illegal    ID/EX register contents
//  Revision    : 1.0  initial release
// ============================================================================
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN  = DEFAULT_XLEN,
    parameter int NREGS = DEFAULT_NREGS
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_instr,
    input  logic                     i_flush,
    input  logic                     i_wb_en,
    input  logic [$clog2(NREGS)-1:0] i_wb_rd,
    input  logic [XLEN-1:0]          i_wb_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [XLEN-1:0]          o_rs1_data,
    output logic [XLEN-1:0]          o_rs2_data,
    output logic [XLEN-1:0]          o_imm,
    output logic [4:0]               o_rd,
    output logic [6:0]               o_funct7,
    output logic [2:0]               o_funct3,
    output logic [1:0]               o_alu_op,
    output logic                     o_alu_src,
    output logic                     o_reg_write,
    output logic                     o_mem_read,
    output logic                     o_mem_write,
    output logic                     o_mem_to_reg,
    output logic                     o_branch,
    output logic                     o_illegal
);

    localparam int c_AW = $clog2(NREGS);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_funct7;

    assign w_opcode = i_instr[6:0];
    assign w_rd     = i_instr[11:7];
    assign w_funct3 = i_instr[14:12];
    assign w_rs1    = i_instr[19:15];
    assign w_rs2    = i_instr[24:20];
    assign w_funct7 = i_instr[31:25];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    id_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (c_AW)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_we     (i_wb_en),
        .i_waddr  (i_wb_rd),
        .i_wdata  (i_wb_data),
        .i_raddr1 (w_rs1[c_AW-1:0]),
        .i_raddr2 (w_rs2[c_AW-1:0]),
        .o_rdata1 (w_rs1_data),
        .o_rdata2 (w_rs2_data)
    );

    // ------------------------------------------------------------------
    // Immediate generation (all sign-extended from instr[31])
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;

    assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};

    // ------------------------------------------------------------------
    // Main control decode
    // ------------------------------------------------------------------
    ctrl_t           w_ctrl;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = ALUOP_ADD;
        w_imm         = '0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_imm             = w_imm_i;
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm            = w_imm_s;
            end
            OP_BRANCH: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
                w_imm         = w_imm_b;
            end
            default: begin
                // Unsupported opcode still travels down the pipe as a bubble-like
                // instruction with no side effects, flagged as illegal.
                w_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd;
    logic [6:0]      r_funct7;
    logic [2:0]      r_funct3;
    logic            w_accept;

    assign o_ready  = !r_valid || i_ready;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
            r_funct7   <= '0;
            r_funct3   <= '0;
        end else begin
            // Flush wins over a simultaneous capture; the captured payload is
            // still loaded below but is never marked valid.
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end

            if (w_accept) begin
                r_ctrl     <= w_ctrl;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= w_imm;
                r_rd       <= w_rd;
                r_funct7   <= w_funct7;
                r_funct3   <= w_funct3;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_rs1_data   = r_rs1_data;
    assign o_rs2_data   = r_rs2_data;
    assign o_imm        = r_imm;
    assign o_rd         = r_rd;
    assign o_funct7     = r_funct7;
    assign o_funct3     = r_funct3;
    assign o_alu_op     = r_ctrl.alu_op;
    assign o_alu_src    = r_ctrl.alu_src;
    assign o_reg_write  = r_ctrl.reg_write;
    assign o_mem_read   = r_ctrl.mem_read;
    assign o_mem_write  = r_ctrl.mem_write;
    assign o_mem_to_reg = r_ctrl.mem_to_reg;
    assign o_branch     = r_ctrl.branch;
    assign o_illegal    = r_ctrl.illegal;

endmodule : id_stage
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage. Directed scenarios followed
//                by randomized traffic, all compared against a behavioural
//                model of the stage (register array + one-entry output slot).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid, o_ready, i_flush, i_wb_en, o_valid, i_ready;
    logic [31:0] i_instr, i_wb_data;
    logic [4:0]  i_wb_rd;
    logic [31:0] o_rs1_data, o_rs2_data, o_imm;
    logic [4:0]  o_rd;
    logic [6:0]  o_funct7;
    logic [2:0]  o_funct3;
    logic [1:0]  o_alu_op;
    logic        o_alu_src, o_reg_write, o_mem_read, o_mem_write;
    logic        o_mem_to_reg, o_branch, o_illegal;

    always #5 i_clk = ~i_clk;

    id_stage u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_instr      (i_instr),
        .i_flush      (i_flush),
        .i_wb_en      (i_wb_en),
        .i_wb_rd      (i_wb_rd),
        .i_wb_data    (i_wb_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_rs1_data   (o_rs1_data),
        .o_rs2_data   (o_rs2_data),
        .o_imm        (o_imm),
        .o_rd         (o_rd),
        .o_funct7     (o_funct7),
        .o_funct3     (o_funct3),
        .o_alu_op     (o_alu_op),
        .o_alu_src    (o_alu_src),
        .o_reg_write  (o_reg_write),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_mem_to_reg (o_mem_to_reg),
        .o_branch     (o_branch),
        .o_illegal    (o_illegal)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [1:0]  alu_op;
        logic        alu_src, rw, mr, mw, m2r, br, ill;
    } exp_t;

    logic [31:0] m_regs [32];
    logic        m_valid;
    exp_t        m_out;

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        int   v;
        e = '0;
        e.rd = ins[11:7];
        e.f3 = ins[14:12];
        e.f7 = ins[31:25];
        case (ins[6:0])
            7'h33: begin e.rw = 1; e.alu_op = 2; end
            7'h03: begin
                e.rw = 1; e.mr = 1; e.m2r = 1; e.alu_src = 1;
                v = int'(ins[31:20]);
                if (v >= 2048) v -= 4096;
                e.imm = v;
            end
            7'h23: begin
                e.mw = 1; e.alu_src = 1;
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (v >= 2048) v -= 4096;
                e.imm = v;
            end
            7'h63: begin
                e.br = 1; e.alu_op = 1;
                v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048
                  + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (ins[31]) v -= 8192;
                e.imm = v;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (i_wb_en && i_wb_rd == rs) return i_wb_data;
        return m_regs[rs];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0;
        m_out   = '0;
    endtask

    task automatic check_outputs();
        chk("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("rs1_data",   o_rs1_data, m_out.rs1);
            chk("rs2_data",   o_rs2_data, m_out.rs2);
            chk("imm",        o_imm, m_out.imm);
            chk("rd",         {27'b0, o_rd}, {27'b0, m_out.rd});
            chk("funct7",     {25'b0, o_funct7}, {25'b0, m_out.f7});
            chk("funct3",     {29'b0, o_funct3}, {29'b0, m_out.f3});
            chk("ctrl",
                {22'b0, o_alu_op, o_alu_src, o_reg_write, o_mem_read, o_mem_write,
                 o_mem_to_reg, o_branch, o_illegal, 1'b0},
                {22'b0, m_out.alu_op, m_out.alu_src, m_out.rw, m_out.mr, m_out.mw,
                 m_out.m2r, m_out.br, m_out.ill, 1'b0});
        end
    endtask

    // One clock cycle: apply inputs, check o_ready, advance model, check outputs.
    task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic rdy);
        logic exp_ready, acc, nxt_valid;
        exp_t nxt;
        i_valid = v; i_instr = ins; i_flush = fl;
        i_wb_en = we; i_wb_rd = wr; i_wb_data = wd; i_ready = rdy;
        #2;
        exp_ready = !m_valid || rdy;
        chk("o_ready", {31'b0, o_ready}, {31'b0, exp_ready});
        acc = v && exp_ready;
        nxt = m_out;
        if (acc) begin
            nxt     = ref_decode(ins);
            nxt.rs1 = ref_operand(ins[19:15]);
            nxt.rs2 = ref_operand(ins[24:20]);
        end
        if (fl)       nxt_valid = 1'b0;
        else if (acc) nxt_valid = 1'b1;
        else if (rdy) nxt_valid = 1'b0;
        else          nxt_valid = m_valid;
        @(posedge i_clk);
        #1;
        if (we && wr != 0) m_regs[wr] = wd;
        m_valid = nxt_valid;
        m_out   = nxt;
        check_outputs();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [31:0] ADD_X3 = 32'h002081B3;
    localparam logic [31:0] LW_X4  = 32'hFF80A203;
    localparam logic [31:0] SW_X2  = 32'h0020A623;
    localparam logic [31:0] BEQ    = 32'hFE208EE3;
    localparam logic [31:0] ADD_X0 = 32'h000002B3;

    logic [6:0] ops [5];

    initial begin
        logic [31:0] r, ins;
        ops[0] = 7'h33; ops[1] = 7'h03; ops[2] = 7'h23; ops[3] = 7'h63; ops[4] = 7'h00;

        // Reset
        i_rst_n = 1'b0; i_valid = 0; i_instr = 0; i_flush = 0;
        i_wb_en = 0; i_wb_rd = 0; i_wb_data = 0; i_ready = 0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_rs1",   o_rs1_data, 32'h0);
        chk("rst_imm",   o_imm, 32'h0);
        chk("rst_ctrl",  {25'b0, o_alu_op, o_reg_write, o_mem_read, o_branch, o_illegal, o_alu_src}, 32'h0);
        i_rst_n = 1'b1;

        // Write-back x1=5, x2=7 then add x3,x1,x2
        drive(0, 0, 0, 1, 1, 5, 1);
        drive(0, 0, 0, 1, 2, 7, 1);
        drive(1, ADD_X3, 0, 0, 0, 0, 1);
        chk("add_rs1", o_rs1_data, 5);
        chk("add_rs2", o_rs2_data, 7);
        chk("add_rd",  {27'b0, o_rd}, 3);
        chk("add_aluop", {30'b0, o_alu_op}, 2);

        drive(1, LW_X4, 0, 0, 0, 0, 1);
        chk("lw_imm", o_imm, 32'hFFFFFFF8);
        chk("lw_memrd", {31'b0, o_mem_read}, 1);
        drive(1, SW_X2, 0, 0, 0, 0, 1);
        chk("sw_imm", o_imm, 12);
        chk("sw_rw", {31'b0, o_reg_write}, 0);
        drive(1, BEQ, 0, 0, 0, 0, 1);
        chk("beq_imm", o_imm, 32'hFFFFFFFC);
        chk("beq_aluop", {30'b0, o_alu_op}, 1);

        // Backpressure: three stalled cycles, then release
        for (int k = 0; k < 3; k++) begin
            drive(1, SW_X2, 0, 0, 0, 0, 0);
            chk("bp_hold_imm", o_imm, 32'hFFFFFFFC);
        end
        drive(1, SW_X2, 0, 0, 0, 0, 1);
        chk("bp_release_imm", o_imm, 12);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("bp_drain", {31'b0, o_valid}, 0);

        // Bypass and x0
        drive(1, ADD_X3, 0, 1, 1, 32'hDEADBEEF, 1);
        chk("bypass_rs1", o_rs1_data, 32'hDEADBEEF);
        drive(0, 0, 0, 1, 0, 32'h1234, 1);
        drive(1, ADD_X0, 0, 1, 0, 32'h5678, 1);
        chk("x0_rs1", o_rs1_data, 0);

        // Flush with capture, illegal opcode
        drive(1, ADD_X3, 1, 0, 0, 0, 1);
        chk("flush_valid", {31'b0, o_valid}, 0);
        drive(1, 32'h0020807F, 0, 0, 0, 0, 1);
        chk("ill_flag", {31'b0, o_illegal}, 1);
        chk("ill_ctrl", {26'b0, o_alu_op, o_reg_write, o_mem_read, o_mem_write, o_branch}, 0);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            r   = $urandom();
            ins = $urandom();
            ins[6:0]   = ops[$urandom_range(0, 4)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'(r[6:0] | 7'h10);
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive(r[8] | r[9], ins, (r[12:10] == 0), r[13],
                  5'($urandom_range(0, 7)), $urandom(), r[14] | r[15]);
        end

        // Asynchronous reset while holding a valid instruction
        drive(1, LW_X4, 0, 0, 0, 0, 0);
        drive(1, LW_X4, 0, 0, 0, 0, 0);
        chk("pre_async_valid", {31'b0, o_valid}, 1);
        i_valid = 0; i_wb_en = 0; i_flush = 0;
        i_rst_n = 1'b0;
        #2;
        chk("async_valid", {31'b0, o_valid}, 0);
        chk("async_imm", o_imm, 0);
        model_reset();
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        drive(1, ADD_X3, 0, 0, 0, 0, 1);
        chk("post_rst_rs1", o_rs1_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_id_stage
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly upstream of the execute stage (alu_control + alu).
- Accepts a fetched 32-bit instruction and decodes main control, including the 2-bit alu_op, funct7 and funct3.
- Reads two operands from an internal 32x32 register file, with write-back bypass, and generates the sign-extended immediate.
- Registers everything into one ID/EX pipeline register with a valid/ready handshake on both sides, plus flush.

Parameters:
- XLEN, 32, data/operand width.
- NREGS, 32, register-file depth; register index width is log2(NREGS) = 5.

Ports:
- i_clk  in  1  sole clock; all state updates on rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction this cycle.
- i_instr  in  32  instruction word.
- i_flush  in  1  kill the held instruction (branch taken).
- i_wb_en  in  1  write-back enable.
- i_wb_rd  in  5  write-back destination.
- i_wb_data  in  XLEN  write-back value.
- o_valid  out  1  ID/EX register holds an instruction.
- i_ready  in  1  execute stage accepts.
- o_rs1_data, o_rs2_data  out  XLEN  operand values.
- o_imm  out  XLEN  sign-extended immediate.
- o_rd  out  5  destination register.
- o_funct7  out  7  instr[31:25].
- o_funct3  out  3  instr[14:12].
- o_alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- o_alu_src  out  1  1 selects o_imm as ALU operand B.
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_branch  out  1 each  main control.
- o_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (i_rst_n=0, asynchronous): o_valid=0 and every registered output=0. All register-file entries=0.
- Handshake:
  - o_ready = !o_valid || i_ready (combinational).
  - Capture when i_valid && o_ready; on the next edge o_valid=1 and the outputs reflect that instruction.
  - When o_valid && !i_ready, all outputs hold stable.
  - If o_valid && i_ready && !i_valid, o_valid goes 0 next edge.
- Latency: exactly 1 cycle from accept to o_valid. Throughput 1/cycle when i_ready is held high.
- Flush:
  - i_flush=1 forces o_valid=0 at the next edge.
  - Flush has priority over a simultaneous capture: the instruction offered that cycle is accepted (o_ready obeys the normal rule) but discarded.
  - Data outputs are don't-care while o_valid=0.
- Decode, by opcode instr[6:0]:
  - 0110011 R: reg_write=1, alu_op=10, alu_src=0, imm=0.
  - 0000011 load: reg_write, mem_read, mem_to_reg, alu_src=1; alu_op=00; I-immediate.
  - 0100011 store: mem_write, alu_src=1; alu_op=00; S-immediate.
  - 1100011 branch: branch=1, alu_op=01, alu_src=0; B-immediate.
  - Other opcodes: o_illegal=1, all control bits 0, alu_op=00, imm=0; still handshakes as a normal instruction.
- Immediates, sign-extended from bit 31:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- Register file:
  - Two combinational read ports indexed by instr[19:15] and instr[24:20].
  - One synchronous write port: written at the edge when i_wb_en && i_wb_rd!=0. Writes occur regardless of the handshake or i_flush.
  - x0 always reads 0 and is never written.
  - Bypass: if i_wb_en && i_wb_rd==rsN && rsN!=0 in the capture cycle, the captured operand is i_wb_data.
- Reset mid-operation: held instruction lost, register file cleared, o_valid=0 immediately (asynchronous).

Decomposition:
- Shared package holds:
  - Opcode constants: OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - alu_op encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - XLEN default.
- One sub-module: regfile (2R1W, x0 hardwired, async reset, write-first bypass).
- Control decode and immediate generation stay inline.

Test Plan:
- Reset, then the write-back sequence (x1=5, x2=7), then add x3,x1,x2 (0x002081B3) with i_ready=1 -> one cycle later: o_valid=1, rs1=5, rs2=7, rd=3, alu_op=10, funct3=0, funct7=0, reg_write=1, alu_src=0.
- lw x4,-8(x1) (0xFF80A203) -> imm=0xFFFFFFF8, alu_op=00, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
- sw x2,12(x1) (0x0020A623) -> imm=12, mem_write=1, reg_write=0. Then beq x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC, branch=1, alu_op=01.
- Backpressure: i_ready=0 with continuous i_valid -> o_ready=0 and outputs frozen for 3 cycles. Release -> next instruction appears one cycle later with no loss or duplication.
- Bypass and x0:
  - i_wb_en=1, rd=1, data=0xDEADBEEF in the same cycle as capturing add x3,x1,x2 -> o_rs1_data=0xDEADBEEF.
  - A write to x0 -> later reads of x0 return 0.
- Flush with simultaneous capture, plus opcode 0x7F:
  - Flush + capture -> o_valid=0 next cycle.
  - Opcode 0x7F -> o_illegal=1, all control bits 0.
  - Assert i_rst_n=0 while o_valid=1 -> o_valid drops without a clock edge.
